// File: rtl/des_round_ctrl.sv
// Sequencer for the iterative DES round datapath: accepts one job, owns the
// C/D key-schedule registers and round counter, and steps 16 Feistel rounds.
module des_round_ctrl #(
  parameter int unsigned LOAD_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [55:0] in_key,
  output logic        dp_load,
  output logic        dp_round_en,
  output logic [3:0]  dp_round,
  output logic [55:0] dp_cd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic        mode, mode_next;
  logic [3:0]  cnt, cnt_next;
  logic [27:0] c, c_next;
  logic [27:0] d, d_next;
  logic [3:0]  n;
  logic [1:0]  s;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Per-round shift for the step that produces round n's key.
  function automatic logic [1:0] shift_amt(input logic [3:0] idx);
    return (idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= 1'b0;
      cnt   <= 4'd0;
      c     <= 28'd0;
      d     <= 28'd0;
    end else begin
      state <= state_next;
      mode  <= mode_next;
      cnt   <= cnt_next;
      c     <= c_next;
      d     <= d_next;
    end
  end

  always_comb begin
    state_next  = state;
    mode_next   = mode;
    cnt_next    = cnt;
    c_next      = c;
    d_next      = d;
    n           = cnt + 4'd1;
    s           = shift_amt(n);
    in_ready    = (state == IDLE);
    busy        = (state != IDLE);
    dp_round_en = (state == ROUND);
    out_valid   = (state == DONE);
    dp_round    = cnt;
    dp_cd       = {c, d};
    // Without a LOAD state the datapath captures the block during acceptance.
    if (LOAD_CYCLE != 0) dp_load = (state == LOAD);
    else                 dp_load = (state == IDLE) && in_valid;

    case (state)
      IDLE: begin
        if (in_valid) begin
          mode_next = in_decrypt;
          cnt_next  = 4'd0;
          // Decrypt starts from K16's C/D, which equals the unshifted PC-1 key.
          if (in_decrypt) begin
            c_next = in_key[55:28];
            d_next = in_key[27:0];
          end else begin
            c_next = rotl(in_key[55:28], 2'd1);
            d_next = rotl(in_key[27:0], 2'd1);
          end
          state_next = (LOAD_CYCLE != 0) ? LOAD : ROUND;
        end
      end
      LOAD: state_next = ROUND;
      ROUND: begin
        if (cnt == 4'd15) begin
          state_next = DONE;
        end else begin
          cnt_next = n;
          if (mode) begin
            c_next = rotr(c, s);
            d_next = rotr(d, s);
          end else begin
            c_next = rotl(c, s);
            d_next = rotl(d, s);
          end
        end
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: both LOAD_CYCLE variants run side by side
// on shared inputs, with hand-derived key-schedule and latency expectations.
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_decrypt = 1'b0;
  logic [55:0] in_key = 56'd0;
  logic        out_ready = 1'b0;

  logic        rdy1, load1, ren1, ov1, busy1;
  logic [3:0]  rnd1;
  logic [55:0] cd1;
  logic        rdy0, load0, ren0, ov0, busy0;
  logic [3:0]  rnd0;
  logic [55:0] cd0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [55:0] cap1 [16];
  logic [55:0] cap0 [16];
  int lat1, lat0, nl1, nl0, nr1, nr0, bad_order;

  always #5 clk = ~clk;

  des_round_ctrl #(.LOAD_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_decrypt(in_decrypt), .in_key(in_key), .dp_load(load1),
    .dp_round_en(ren1), .dp_round(rnd1), .dp_cd(cd1),
    .out_valid(ov1), .out_ready(out_ready), .busy(busy1)
  );

  des_round_ctrl #(.LOAD_CYCLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_decrypt(in_decrypt), .in_key(in_key), .dp_load(load0),
    .dp_round_en(ren0), .dp_round(rnd0), .dp_cd(cd0),
    .out_valid(ov0), .out_ready(out_ready), .busy(busy0)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ready"},  {rdy1, rdy0},   2'b11);
    check_eq({pfx, "_busy"},   {busy1, busy0}, 2'b00);
    check_eq({pfx, "_load"},   {load1, load0}, 2'b00);
    check_eq({pfx, "_ren"},    {ren1, ren0},   2'b00);
    check_eq({pfx, "_round"},  {rnd1, rnd0},   8'h00);
    check_eq({pfx, "_cd1"},    cd1,            56'd0);
    check_eq({pfx, "_cd0"},    cd0,            56'd0);
    check_eq({pfx, "_ovalid"}, {ov1, ov0},     2'b00);
  endtask

  // Runs one job on both instances with out_ready low; stops once both show
  // out_valid. poke_k > 0 raises in_valid with a junk key for one mid-job cycle.
  task automatic run_job(input logic dec, input logic [55:0] key, input int poke_k);
    for (int i = 0; i < 16; i++) begin
      cap1[i] = '0;
      cap0[i] = '0;
    end
    lat1 = 0; lat0 = 0; nl1 = 0; nl0 = 0; nr1 = 0; nr0 = 0; bad_order = 0;
    in_valid   = 1'b1;
    in_decrypt = dec;
    in_key     = key;
    #1;
    check_eq("accept_ready", rdy1, 1'b1);
    check_eq("accept_load_lc0", load0, 1'b1);
    check_eq("accept_load_lc1", load1, 1'b0);
    tick;
    in_valid   = 1'b0;
    in_decrypt = ~dec;
    in_key     = ~key;
    for (int k = 1; k <= 40; k++) begin
      if (load1) nl1++;
      if (load0) nl0++;
      if (ren1) begin
        if (rnd1 != nr1[3:0]) bad_order++;
        cap1[rnd1] = cd1;
        nr1++;
      end
      if (ren0) begin
        if (rnd0 != nr0[3:0]) bad_order++;
        cap0[rnd0] = cd0;
        nr0++;
      end
      if (ov1 && lat1 == 0) lat1 = k;
      if (ov0 && lat0 == 0) lat0 = k;
      if (lat1 != 0 && lat0 != 0) break;
      if (k == poke_k) begin
        in_valid = 1'b1;
        in_key   = 56'hFF_FFFF_FFFF_FFFF;
      end else begin
        in_valid = 1'b0;
      end
      tick;
    end
    in_valid = 1'b0;
    check_eq("lat_lc1", lat1, 18);
    check_eq("lat_lc0", lat0, 17);
    check_eq("load_cycles_lc1", nl1, 1);
    check_eq("load_cycles_lc0_after_accept", nl0, 0);
    check_eq("round_cycles_lc1", nr1, 16);
    check_eq("round_cycles_lc0", nr0, 16);
    check_eq("round_order", bad_order, 0);
  endtask

  task automatic finish_job;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_eq("post_hs_ready", {rdy1, rdy0}, 2'b11);
    check_eq("post_hs_busy",  {busy1, busy0}, 2'b00);
    check_eq("post_hs_ovalid", {ov1, ov0}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int changes;

    // Reset, then idle with in_valid low.
    tick;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    changes = 0;
    repeat (50) begin
      tick;
      if (rdy1 !== 1'b1 || busy1 !== 1'b0 || ov1 !== 1'b0 || cd1 !== 56'd0 ||
          load1 !== 1'b0 || ren1 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0 ||
          ov0 !== 1'b0 || cd0 !== 56'd0 || load0 !== 1'b0 || ren0 !== 1'b0)
        changes++;
    end
    check_eq("idle_stable", changes, 0);

    // Encrypt, simple key.
    run_job(1'b0, 56'h0000001_0000001, 0);
    check_eq("enc_cd_r0",  cap1[0],  56'h0000002_0000002);
    check_eq("enc_cd_r1",  cap1[1],  56'h0000004_0000004);
    check_eq("enc_cd_r2",  cap1[2],  56'h0000010_0000010);
    check_eq("enc_cd_r15", cap1[15], 56'h0000001_0000001);
    check_eq("enc_cd_r2_lc0",  cap0[2],  56'h0000010_0000010);
    check_eq("enc_cd_r15_lc0", cap0[15], 56'h0000001_0000001);
    finish_job;

    // Decrypt, same key.
    run_job(1'b1, 56'h0000001_0000001, 0);
    check_eq("dec_cd_r0",  cap1[0],  56'h0000001_0000001);
    check_eq("dec_cd_r1",  cap1[1],  56'h8000000_8000000);
    check_eq("dec_cd_r15", cap1[15], 56'h0000002_0000002);
    check_eq("dec_cd_r1_lc0",  cap0[1],  56'h8000000_8000000);
    check_eq("dec_cd_r15_lc0", cap0[15], 56'h0000002_0000002);
    finish_job;

    // Classic DES key 133457799BBCDFF1 after PC-1; junk in_valid pulse mid-round.
    run_job(1'b0, 56'hF0CCAAF_556678F, 8);
    check_eq("des_cd_r0",  cap1[0],  56'hE19955F_AACCF1E);
    check_eq("des_cd_r1",  cap1[1],  56'hC332ABF_5599E3D);
    check_eq("des_cd_r2",  cap1[2],  56'h0CCAAFF_56678F5);
    check_eq("des_cd_r15", cap1[15], 56'hF0CCAAF_556678F);
    check_eq("des_cd_r15_lc0", cap0[15], 56'hF0CCAAF_556678F);

    // Backpressure: DONE holds for 10 cycles, busy input ignored.
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_key   = 56'h1234567_89ABCDE;
      #1;
      if (load0 !== 1'b0 || load1 !== 1'b0) changes++;
      tick;
      if (ov1 !== 1'b1 || ov0 !== 1'b1 || busy1 !== 1'b1 || rdy1 !== 1'b0 ||
          rdy0 !== 1'b0 || ren1 !== 1'b0 || cd1 !== 56'hF0CCAAF_556678F)
        changes++;
    end
    in_valid = 1'b0;
    check_eq("backpressure_hold", changes, 0);
    finish_job;

    // Reset in the middle of round 7.
    in_valid   = 1'b1;
    in_decrypt = 1'b0;
    in_key     = 56'h0000001_0000001;
    tick;
    in_valid = 1'b0;
    repeat (8) tick;
    check_eq("midop_round", {ren1, rnd1}, {1'b1, 4'd7});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) tick;
    rst_n = 1'b1;
    changes = 0;
    repeat (25) begin
      tick;
      if (ov1 !== 1'b0 || ov0 !== 1'b0 || busy1 !== 1'b0 || busy0 !== 1'b0) changes++;
    end
    check_eq("no_ovalid_after_reset", changes, 0);

    // Fresh job after reset completes normally.
    run_job(1'b0, 56'h0000001_0000001, 0);
    check_eq("rerun_cd_r0",  cap1[0],  56'h0000002_0000002);
    check_eq("rerun_cd_r15", cap1[15], 56'h0000001_0000001);
    finish_job;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
